// File: rtl/ram_port_b_arbiter_if.sv
// Requester-side bundle for the port-B arbiter.
// master: requester (req/we/addr/wdata out, ready/rvalid in); slave: arbiter.
interface ram_port_b_arbiter_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int RAM_WIDTH  = 128
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [RAM_WIDTH-1:0]  wdata;
    logic                  ready;
    logic                  rvalid;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid
    );
endinterface

// File: rtl/ram_port_b_arbiter.sv
// Round-robin arbiter sharing RAM port B between m0 (LSU) and m1 (refill).
// Ports: clk, rst (sync, active-low), rdy (freeze), m0/m1 requester
// bundles, rdata (response line), addr_b/din_b/we_b/dout_b (RAM port B).
module ram_port_b_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int RAM_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    ram_port_b_arbiter_if.slave   m0,
    ram_port_b_arbiter_if.slave   m1,
    output logic [RAM_WIDTH-1:0]  rdata,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [RAM_WIDTH-1:0]  din_b,
    output logic                  we_b,
    input  logic [RAM_WIDTH-1:0]  dout_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RAM_WIDTH-1:0]  wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  id_q, id_d;
    logic                  last_q, last_d;
    logic                  rvalid_q, rvalid_d;
    logic [RAM_WIDTH-1:0]  rdata_q, rdata_d;

    logic active;
    logic sel0;
    logic sel1;
    logic gnt0;
    logic gnt1;

    // Outputs are also suppressed while reset is held so an in-flight
    // write cannot reach the RAM and no stale response leaks out.
    assign active = rst & rdy;

    // On a tie the requester that did not win last time is chosen.
    assign sel0 = m0.req & (~m1.req | last_q);
    assign sel1 = m1.req & (~m0.req | ~last_q);

    assign gnt0 = active & (state_q == IDLE) & sel0;
    assign gnt1 = active & (state_q == IDLE) & sel1;

    assign m0.ready  = gnt0;
    assign m1.ready  = gnt1;
    assign m0.rvalid = active & rvalid_q & ~id_q;
    assign m1.rvalid = active & rvalid_q & id_q;

    assign addr_b = addr_q;
    assign din_b  = wdata_q;
    assign we_b   = active & (state_q == ISSUE) & we_q;
    assign rdata  = rdata_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        id_d     = id_q;
        last_d   = last_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        // With rdy low everything holds, so a pending pulse survives.
        if (rdy) begin
            rvalid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        state_d = ISSUE;
                        id_d    = gnt1;
                        last_d  = gnt1;
                        we_d    = gnt1 ? m1.we    : m0.we;
                        addr_d  = gnt1 ? m1.addr  : m0.addr;
                        wdata_d = gnt1 ? m1.wdata : m0.wdata;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    rdata_d  = dout_b;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            id_q     <= id_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
